// File: rtl/mul_shift_add.sv
// Sequential 32x32->64 unsigned shift-add multiplier around the Add carry-lookahead adder.
// Optional MUL_SIGNED_EN adds signed_op and a NEG fix-up state (constant 33-edge latency).
module mul_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef MUL_SIGNED_EN
    NEG  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] add_b, add_sum;
  logic             add_cout;
  logic             last_iter;

  assign add_b     = lo[0] ? mcand : '0;
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  Add u_add (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
`ifdef MUL_SIGNED_EN
      RUN:  if (last_iter) state_nxt = NEG;
      NEG:  state_nxt = DONE;
`else
      RUN:  if (last_iter) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

`ifdef MUL_SIGNED_EN
  logic neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  // magnitude of -2^31 wraps back to 0x80000000, which is the correct unsigned value
  assign a_mag = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
`ifdef MUL_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
`ifdef MUL_SIGNED_EN
          mcand <= a_mag;
          lo    <= b_mag;
          neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
          mcand <= a;
          lo    <= b;
`endif
          hi    <= '0;
          cnt   <= '0;
        end
        RUN: begin
          // 33-bit {carry,sum} shifts right one place into {hi,lo}
          hi  <= {add_cout, add_sum[WIDTH-1:1]};
          lo  <= {add_sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
`ifdef MUL_SIGNED_EN
        NEG: if (neg) {hi, lo} <= ~{hi, lo} + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign product = {hi, lo};

endmodule

// 32-bit adder: 4-bit carry-lookahead groups, group carries rippled.
module Add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_cla
    localparam int B = 4*k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
endmodule

// File: tb/tb_mul_shift_add.sv
// Scoreboard bench for mul_shift_add: driver pushes expected products, monitor pops on output handshake.
module tb_mul_shift_add;
`ifdef MUL_SIGNED_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] a = 0, b = 0;
  logic        signed_op = 0;
  logic        out_valid, out_ready = 1;
  logic [63:0] product;
  logic        busy;

  int tests = 0, fails = 0;
  int cyc = 0;
  int hs_cyc = -100;
  int last_acc = 0;
  logic prev_ov = 0;
  logic [63:0] exp_q[$];
  int          acc_q[$];

  mul_shift_add dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef MUL_SIGNED_EN
    .signed_op(signed_op),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, product on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("spurious_out_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else check("product", product, exp_q.pop_front());
        hs_cyc = cyc + 1;
      end
    end
    prev_ov = out_valid && rst_n;
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic sop,
                       input logic [63:0] exp, input bit push, input bit keep);
    logic rdy;
    int n;
    a = ia; b = ib; signed_op = sop; in_valid = 1;
    n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 200);
    #1;
    if (!rdy) check("accept_timeout", 64'd0, 64'd1);
    last_acc = cyc;
    if (push) begin exp_q.push_back(exp); acc_q.push_back(cyc); end
    if (!keep) in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin @(posedge clk); #1; n++; end
    if (n >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_product", product, 64'd0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // basic and all-carry cases
    issue(32'd3, 32'd5, 0, 64'hF, 1, 0);
    wait_idle();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001, 1, 0);
    wait_idle();

    // stalled output with in_valid held high and new operands
    out_ready = 0;
    issue(32'h12345678, 32'h9ABCDEF0, 0, 64'h0B00EA4E242D2080, 1, 1);
    a = 32'h10; b = 32'h20;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_product", product, 64'h0B00EA4E242D2080);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1;
    issue(32'h10, 32'h20, 0, 64'h200, 1, 0);
    wait_idle();

    // reset abort mid-operation
    issue(32'hFFFF, 32'hFFFF, 0, 64'd0, 0, 0);
    repeat (11) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    issue(32'd7, 32'd9, 0, 64'd63, 1, 0);
    wait_idle();

`ifdef MUL_SIGNED_EN
    issue(32'hFFFFFFFD, 32'd5, 1, 64'hFFFFFFFFFFFFFFF1, 1, 0);
    wait_idle();
    issue(32'h80000000, 32'h80000000, 1, 64'h4000000000000000, 1, 0);
    wait_idle();
    issue(32'hFFFFFFFF, 32'd2, 0, 64'h00000001FFFFFFFE, 1, 0);
    wait_idle();
`endif

    // back-to-back with in_valid held across the handshake
    issue(32'd0, 32'hDEADBEEF, 0, 64'd0, 1, 1);
    a = 32'd1;
    issue(32'd1, 32'hDEADBEEF, 0, 64'h00000000DEADBEEF, 1, 0);
    check("b2b_accept_gap", 64'(last_acc - hs_cyc), 64'd1);
    wait_idle();

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: tests=%0d", tests);
    $fatal(1);
  end
endmodule
